// File: rtl/fetch_flow_ctrl.sv
// fetch_flow_ctrl
// ----------------
// Drives the IF/ID pipeline register and the fetch PC. It combines three
// inputs into the IF/ID stall and flush controls: back-end mispredict
// recovery, decode back-pressure and I-cache miss. After each recovery it
// issues a one-cycle PC redirect and then holds a fixed refill bubble.
//
// Parameters:
//   REFILL_CYC     bubble cycles after a redirect (1..15)
//   STALL_TIMEOUT  consecutive stall cycles before stall_timeout (1..255)
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   mis_pred_in     mispredict pulse from branch resolution
//   recv_pc_in      recovery PC, valid with mis_pred_in
//   dec_full        decode/rename cannot accept (level)
//   icache_miss     fetch data invalid this cycle (level)
//   stall           IF/ID hold
//   flush           IF/ID clear (combinational, same edge as mispredict)
//   fetch_en        fetch PC may advance
//   pc_redirect     one-cycle pulse: load redirect_pc into the fetch PC
//   redirect_pc     registered recovery PC
//   stall_timeout   consecutive-stall watchdog flag
//   perf_stall_cnt  total stall cycles
//   perf_flush_cnt  total accepted mispredicts
//
// Build option:
//   FETCH_PERF_CNT_EN  when defined, the two perf counters are built.
//                      When it is undefined, both perf ports read as 0.

module fetch_flow_ctrl #(
    parameter int REFILL_CYC    = 2,
    parameter int STALL_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mis_pred_in,
    input  logic [63:0] recv_pc_in,
    input  logic        dec_full,
    input  logic        icache_miss,
    output logic        stall,
    output logic        flush,
    output logic        fetch_en,
    output logic        pc_redirect,
    output logic [63:0] redirect_pc,
    output logic        stall_timeout,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        FLUSH  = 2'd2,
        REFILL = 2'd3
    } state_t;

    localparam logic [3:0] REFILL_INIT = 4'(REFILL_CYC);
    localparam logic [7:0] WDOG_MAX    = 8'(STALL_TIMEOUT);

    state_t      state_reg;
    logic [3:0]  refill_cnt_reg;
    logic [7:0]  wdog_cnt_reg;
    logic [7:0]  wdog_cnt_next;
    logic        pc_redirect_reg;
    logic [63:0] redirect_pc_reg;
    logic        stall_timeout_reg;

    logic        stall_src;
    logic        flush_raw;

    // flush does not wait for a register. IF/ID is cleared on the same edge
    // that samples the mispredict. Both controls are held low during reset
    // so that IF/ID never sees a flush or stall while reset is asserted.
    always_comb begin
        stall_src = dec_full | icache_miss;
        flush_raw = mis_pred_in | (state_reg == FLUSH) | (state_reg == REFILL);
        flush     = rst_n & flush_raw;
        stall     = rst_n & stall_src & ~flush_raw;
        fetch_en  = ~stall & (state_reg != FLUSH);
    end

    // The watchdog counts consecutive stall cycles and saturates at the
    // threshold. Any cycle without a stall clears it.
    always_comb begin
        wdog_cnt_next = 8'd0;
        if (stall) begin
            wdog_cnt_next = (wdog_cnt_reg == WDOG_MAX) ? WDOG_MAX : wdog_cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= RUN;
            refill_cnt_reg    <= 4'd0;
            wdog_cnt_reg      <= 8'd0;
            pc_redirect_reg   <= 1'b0;
            redirect_pc_reg   <= 64'd0;
            stall_timeout_reg <= 1'b0;
        end else begin
            pc_redirect_reg <= 1'b0;
            if (mis_pred_in) begin
                // A mispredict in any state restarts the recovery sequence.
                // The newest recovery PC replaces the one held before.
                state_reg       <= FLUSH;
                redirect_pc_reg <= recv_pc_in;
                pc_redirect_reg <= 1'b1;
            end else begin
                case (state_reg)
                    RUN: begin
                        if (stall_src) state_reg <= STALL;
                    end
                    STALL: begin
                        if (!stall_src) state_reg <= RUN;
                    end
                    FLUSH: begin
                        refill_cnt_reg <= REFILL_INIT;
                        state_reg      <= REFILL;
                    end
                    REFILL: begin
                        refill_cnt_reg <= refill_cnt_reg - 4'd1;
                        if (refill_cnt_reg <= 4'd1) begin
                            state_reg <= stall_src ? STALL : RUN;
                        end
                    end
                endcase
            end
            wdog_cnt_reg      <= wdog_cnt_next;
            stall_timeout_reg <= (wdog_cnt_next == WDOG_MAX);
        end
    end

    assign pc_redirect   = pc_redirect_reg;
    assign redirect_pc   = redirect_pc_reg;
    assign stall_timeout = stall_timeout_reg;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cnt_reg;
    logic [31:0] perf_flush_cnt_reg;

    // These counters wrap freely. They are event totals, not rates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt_reg <= 32'd0;
            perf_flush_cnt_reg <= 32'd0;
        end else begin
            if (stall)       perf_stall_cnt_reg <= perf_stall_cnt_reg + 32'd1;
            if (mis_pred_in) perf_flush_cnt_reg <= perf_flush_cnt_reg + 32'd1;
        end
    end

    assign perf_stall_cnt = perf_stall_cnt_reg;
    assign perf_flush_cnt = perf_flush_cnt_reg;
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_flow_ctrl.sv
module tb_fetch_flow_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mis_pred_in;
    logic [63:0] recv_pc_in;
    logic        dec_full;
    logic        icache_miss;
    logic        stall;
    logic        flush;
    logic        fetch_en;
    logic        pc_redirect;
    logic [63:0] redirect_pc;
    logic        stall_timeout;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_flow_ctrl #(.REFILL_CYC(2), .STALL_TIMEOUT(255)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mis_pred_in    (mis_pred_in),
        .recv_pc_in     (recv_pc_in),
        .dec_full       (dec_full),
        .icache_miss    (icache_miss),
        .stall          (stall),
        .flush          (flush),
        .fetch_en       (fetch_en),
        .pc_redirect    (pc_redirect),
        .redirect_pc    (redirect_pc),
        .stall_timeout  (stall_timeout),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );

    typedef struct {
        logic        mp;
        logic [63:0] pc;
        logic        df;
        logic        im;
        logic        e_stall;
        logic        e_flush;
        logic        e_fen;
        logic        e_redir;
        logic [63:0] e_rpc;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    function automatic vec_t row(logic mp, logic [63:0] pc, logic df, logic im,
                                 logic s, logic f, logic fe, logic rd, logic [63:0] rpc);
        vec_t v;
        v.mp = mp; v.pc = pc; v.df = df; v.im = im;
        v.e_stall = s; v.e_flush = f; v.e_fen = fe; v.e_redir = rd; v.e_rpc = rpc;
        return v;
    endfunction

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        mis_pred_in = 1'b0;
        recv_pc_in  = 64'd0;
        dec_full    = 1'b0;
        icache_miss = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish (got running, expected done)");
        $fatal(1);
    end

    initial begin
        vec_t e;
        // Vector table (REFILL_CYC=2). Each row is one cycle:
        // inputs, then stall, flush, fetch_en, pc_redirect, redirect_pc.
        tbl.push_back(row(0, 64'h0,    0, 0,  0, 0, 1, 0, 64'h0));    // idle after reset
        tbl.push_back(row(1, 64'h4000, 0, 0,  0, 1, 1, 0, 64'h0));    // cycle N-1
        tbl.push_back(row(0, 64'h0,    0, 0,  0, 1, 0, 1, 64'h4000)); // FLUSH
        tbl.push_back(row(0, 64'h0,    0, 0,  0, 1, 1, 0, 64'h4000)); // REFILL 1
        tbl.push_back(row(0, 64'h0,    0, 0,  0, 1, 1, 0, 64'h4000)); // REFILL 2
        tbl.push_back(row(0, 64'h0,    0, 0,  0, 0, 1, 0, 64'h4000)); // RUN
        tbl.push_back(row(1, 64'h1000, 0, 0,  0, 1, 1, 0, 64'h4000));
        tbl.push_back(row(0, 64'h0,    0, 0,  0, 1, 0, 1, 64'h1000)); // FLUSH
        tbl.push_back(row(1, 64'h8000, 0, 0,  0, 1, 1, 0, 64'h1000)); // REFILL, new mispredict
        tbl.push_back(row(0, 64'h0,    0, 0,  0, 1, 0, 1, 64'h8000)); // FLUSH again
        tbl.push_back(row(0, 64'h0,    0, 0,  0, 1, 1, 0, 64'h8000)); // REFILL 1
        tbl.push_back(row(0, 64'h0,    0, 0,  0, 1, 1, 0, 64'h8000)); // REFILL 2
        tbl.push_back(row(0, 64'h0,    0, 0,  0, 0, 1, 0, 64'h8000)); // RUN
        tbl.push_back(row(1, 64'hC000, 0, 1,  0, 1, 1, 0, 64'h8000)); // miss + mispredict
        tbl.push_back(row(0, 64'h0,    0, 1,  0, 1, 0, 1, 64'hC000)); // FLUSH
        tbl.push_back(row(0, 64'h0,    0, 1,  0, 1, 1, 0, 64'hC000)); // REFILL 1
        tbl.push_back(row(0, 64'h0,    0, 1,  0, 1, 1, 0, 64'hC000)); // REFILL 2
        tbl.push_back(row(0, 64'h0,    0, 1,  1, 0, 0, 0, 64'hC000)); // STALL resumes
        tbl.push_back(row(0, 64'h0,    0, 0,  0, 0, 1, 0, 64'hC000)); // miss clears
        tbl.push_back(row(0, 64'h0,    1, 0,  1, 0, 0, 0, 64'hC000)); // dec_full stall
        tbl.push_back(row(0, 64'h0,    0, 0,  0, 0, 1, 0, 64'hC000)); // idle

        // Reset: the stall and flush outputs are held low while reset is asserted.
        rst_n = 1'b0;
        drive_idle();
        dec_full    = 1'b1;
        mis_pred_in = 1'b1;
        #1;
        check("rst_stall_gated", stall, 0);
        check("rst_flush_gated", flush, 0);
        check("rst_pc_redirect", pc_redirect, 0);
        check("rst_redirect_pc", redirect_pc, 0);
        check("rst_stall_timeout", stall_timeout, 0);
        drive_idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_perf_stall", perf_stall_cnt, 0);
        check("rst_perf_flush", perf_flush_cnt, 0);

        // Table-driven run through the scoreboard.
        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            mis_pred_in = tbl[i].mp;
            recv_pc_in  = tbl[i].pc;
            dec_full    = tbl[i].df;
            icache_miss = tbl[i].im;
            exp_q.push_back(tbl[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            $display("row %0d mp=%0b df=%0b im=%0b -> stall=%0b flush=%0b fetch_en=%0b redir=%0b pc=0x%0h",
                     i, e.mp, e.df, e.im, stall, flush, fetch_en, pc_redirect, redirect_pc);
            check($sformatf("row%0d_stall", i), stall, e.e_stall);
            check($sformatf("row%0d_flush", i), flush, e.e_flush);
            check($sformatf("row%0d_fetch_en", i), fetch_en, e.e_fen);
            check($sformatf("row%0d_pc_redirect", i), pc_redirect, e.e_redir);
            check($sformatf("row%0d_redirect_pc", i), redirect_pc, e.e_rpc);
        end
        @(posedge clk);
        #1 drive_idle();
        @(negedge clk);
        check("tbl_perf_flush", perf_flush_cnt, PERF_ON ? 32'd4 : 32'd0);
        check("tbl_perf_stall", perf_stall_cnt, PERF_ON ? 32'd2 : 32'd0);
        check("tbl_exp_q_empty", exp_q.size(), 0);

        // Reset asserted during the FLUSH cycle abandons the redirect.
        @(posedge clk);
        #1;
        mis_pred_in = 1'b1;
        recv_pc_in  = 64'hDEAD_0000;
        @(posedge clk);
        #1 drive_idle();
        dec_full = 1'b1;
        check("flush_cycle_redirect", pc_redirect, 1);
        #2 rst_n = 1'b0;
        #1;
        $display("async reset in FLUSH: redir=%0b pc=0x%0h flush=%0b stall=%0b",
                 pc_redirect, redirect_pc, flush, stall);
        check("async_rst_pc_redirect", pc_redirect, 0);
        check("async_rst_redirect_pc", redirect_pc, 0);
        check("async_rst_flush", flush, 0);
        check("async_rst_stall", stall, 0);
        check("async_rst_fetch_en", fetch_en, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        dec_full = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("post_rst_redirect_%0d", i), pc_redirect, 0);
            check($sformatf("post_rst_flush_%0d", i), flush, 0);
        end
        check("post_rst_perf_flush", perf_flush_cnt, 0);

        // dec_full held for 300 cycles. The watchdog threshold is 255.
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1 dec_full = 1'b1;
            @(negedge clk);
            check($sformatf("wd_stall_%0d", i), stall, 1);
            check($sformatf("wd_fetch_en_%0d", i), fetch_en, 0);
            check($sformatf("wd_timeout_%0d", i), stall_timeout, (i >= 255) ? 1 : 0);
        end
        $display("watchdog: 300 stall cycles, stall_timeout=%0b", stall_timeout);
        @(posedge clk);
        #1 dec_full = 1'b0;
        @(negedge clk);
        check("wd_drop_stall", stall, 0);
        check("wd_drop_timeout_still_high", stall_timeout, 1);
        check("wd_perf_stall", perf_stall_cnt, PERF_ON ? 32'd300 : 32'd0);
        @(negedge clk);
        check("wd_timeout_cleared", stall_timeout, 0);
        check("wd_perf_stall_hold", perf_stall_cnt, PERF_ON ? 32'd300 : 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_flow_ctrl.md
# fetch_flow_ctrl

Sequencing controller for the IF/ID pipeline register and the fetch PC. Merges back-end mispredict recovery, decode back-pressure and I-cache miss into the `stall` and `flush` controls of IF/ID. Issues a single-cycle PC redirect and inserts a fixed refill bubble after each recovery. Sits between the fetch unit, IF/ID and the branch-resolution logic.

## Interface
Parameters:
- `REFILL_CYC`, default 2: bubble cycles after a redirect. Legal range 1..15.
- `STALL_TIMEOUT`, default 255: consecutive stall cycles before `stall_timeout` asserts. Legal range 1..255.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mis_pred_in`  in  1  mispredict pulse from branch resolution.
- `recv_pc_in`  in  64  recovery PC, valid with `mis_pred_in`.
- `dec_full`  in  1  level; decode/rename cannot accept.
- `icache_miss`  in  1  level; fetch data invalid this cycle.
- `stall`  out  1  to IF/ID stall (hold).
- `flush`  out  1  to IF/ID mis_pred (zero instruction field).
- `fetch_en`  out  1  allow fetch PC to advance.
- `pc_redirect`  out  1  one-cycle pulse: load `redirect_pc` into fetch PC.
- `redirect_pc`  out  64  registered recovery PC.
- `stall_timeout`  out  1  consecutive-stall watchdog flag.
- `perf_stall_cnt`  out  32  total stall cycles.
- `perf_flush_cnt`  out  32  total accepted mispredicts.

## Operation
- FSM states: RUN, STALL, FLUSH, REFILL. Reset state is RUN.
- Priority in every state: `mis_pred_in` > refill sequencing > (`dec_full` | `icache_miss`).
- RUN:
  - `mis_pred_in` -> FLUSH, latching `recv_pc_in`.
  - Otherwise `dec_full`|`icache_miss` -> STALL.
  - Otherwise stay in RUN.
- STALL:
  - `mis_pred_in` -> FLUSH.
  - Both stall sources low -> RUN.
  - Otherwise stay in STALL.
- FLUSH (exactly 1 cycle): `pc_redirect`=1 and `redirect_pc` = latched PC. Loads the refill counter with `REFILL_CYC`. Next state is REFILL.
- REFILL: counter decrements each cycle. When it reaches 1:
  - go to STALL if a stall source is high;
  - otherwise go to RUN.
- `mis_pred_in` during FLUSH or REFILL: relatch `recv_pc_in`, return to FLUSH, restart the sequence. The newest PC wins.
- `flush` = `mis_pred_in` | state∈{FLUSH, REFILL}. It is combinational, so IF/ID clears on the same edge that the mispredict is sampled.
- `stall` = (`dec_full`|`icache_miss`) & ~`flush`. Flush has priority, so stall and flush are never both 1.
- `fetch_en` = ~`stall` & state≠FLUSH.
- Watchdog counter (8 bits):
  - Clears on any cycle with `stall`=0.
  - Increments on each `stall`=1 cycle and saturates at `STALL_TIMEOUT`.
  - `stall_timeout` is registered. It is 1 while the counter equals `STALL_TIMEOUT` and drops the cycle after `stall` falls.
- Reset values:
  - state RUN;
  - `pc_redirect` 0, `redirect_pc` 0, `stall_timeout` 0;
  - watchdog, refill and perf counters 0.
- `stall` and `flush` are gated low while `rst_n`=0.
- Reset asserted mid-sequence abandons the redirect; no `pc_redirect` is issued after release.

## Timing
- Mispredict sampled at edge N: `flush`=1 in cycle N-1 (combinational) and in cycles N … N+REFILL_CYC.
- `pc_redirect` pulses in cycle N (FLUSH).
- First non-flushed IF/ID capture happens at the end of cycle N+REFILL_CYC+1.
- Stall has zero latency: `stall` follows the inputs combinationally. The STALL state and the watchdog update on the next edge.
- Perf counters are registered and update one cycle after the event. They wrap at 2^32 with no saturation.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - `perf_stall_cnt` increments on each cycle with `stall`=1.
  - `perf_flush_cnt` increments on each FLUSH-state entry.
- `FETCH_PERF_CNT_EN` undefined: the counter registers are not built and both ports are tied to 0. The ports remain present.

## Test plan
- Reset, then idle inputs: state RUN; `stall`=0, `flush`=0, `fetch_en`=1, `pc_redirect`=0, `redirect_pc`=0.
- `mis_pred_in` pulse with `recv_pc_in`=0x0000_0000_0000_4000 at edge N, REFILL_CYC=2:
  - `flush`=1 for cycles N-1..N+2;
  - single `pc_redirect` in cycle N with `redirect_pc`=0x4000;
  - `fetch_en`=0 only in cycle N;
  - `perf_flush_cnt`=1.
- Second mispredict (PC 0x8000) during REFILL: FSM returns to FLUSH, `pc_redirect` pulses again with 0x8000, and the refill restarts for 2 full cycles.
- `dec_full` held for 300 cycles, STALL_TIMEOUT=255:
  - `stall`=1 and `fetch_en`=0 throughout;
  - `stall_timeout` rises after 255 stall cycles and clears the cycle after `dec_full` drops;
  - `perf_stall_cnt`=300.
- `icache_miss`=1 and `mis_pred_in`=1 in the same cycle: `stall`=0, `flush`=1, FLUSH entered. Stall resumes after refill if `icache_miss` is still high.
- `rst_n` low in the FLUSH cycle: outputs return to reset values asynchronously, and no redirect appears after release.
